gcd_datapath: RTL

- Datapath stage directly downstream of the GCD control FSM.
- Consumes x_load/y_load/x_sel/y_sel/gcd_load and produces eq_flag/if_flag back to control.
- Holds one pending operand pair captured via a valid/ready input handshake.
- Runs the subtractive x/y working registers and presents the result through a valid/ready output register with iteration count and error status.

---
 rtl/gcd_datapath_if.sv | 56 +++++
 rtl/gcd_datapath.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/gcd_datapath_if.sv
// Bundle of handshake, control and status signals between GCD control and datapath.
// Latency: none; wires only.
// Backpressure: carries in_valid/in_ready and out_valid/out_ready. The endpoints implement them.
//
// Modports:
//   master : control/environment side. Drives operands, control strobes and out_ready.
//   slave  : datapath side. Drives in_ready, flags, result and status.
interface gcd_datapath_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 8
);
    // operand input handshake
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;

    // control strobes from the FSM
    logic             x_load;
    logic             y_load;
    logic             x_sel;
    logic             y_sel;
    logic             gcd_load;

    // status back to the FSM
    logic             eq_flag;
    logic             if_flag;

    // result output handshake
    logic [WIDTH-1:0] gcd_out;
    logic [CW-1:0]    iter_out;
    logic             out_valid;
    logic             out_ready;

    // error status
    logic             zero_err;
    logic             ovf_err;

    modport master (
        output in_valid, x_in, y_in,
        output x_load, y_load, x_sel, y_sel, gcd_load,
        output out_ready,
        input  in_ready, eq_flag, if_flag,
        input  gcd_out, iter_out, out_valid,
        input  zero_err, ovf_err
    );

    modport slave (
        input  in_valid, x_in, y_in,
        input  x_load, y_load, x_sel, y_sel, gcd_load,
        input  out_ready,
        output in_ready, eq_flag, if_flag,
        output gcd_out, iter_out, out_valid,
        output zero_err, ovf_err
    );
endinterface

// File: rtl/gcd_datapath.sv
// Subtractive GCD datapath: pending operand buffer, x/y working registers and result register.
// Latency: input capture is 1 edge, operand load to flags is 1 edge, gcd_load to out_valid is 1 edge.
// Backpressure: in_ready drops while a pair is pending. An unread result that is overwritten sets sticky ovf_err.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : gcd_datapath_if.slave
//           - in_valid/in_ready/x_in/y_in    : operand pair handshake
//           - x_load/y_load/x_sel/y_sel      : working register control
//           - gcd_load                       : result capture strobe
//           - eq_flag/if_flag                : x==y, x<y back to control
//           - gcd_out/iter_out/out_valid/out_ready : result handshake
//           - zero_err/ovf_err               : status
module gcd_datapath #(
    parameter int WIDTH = 8,
    parameter int CW    = 8
) (
    input  logic           clk,
    input  logic           reset,
    gcd_datapath_if.slave  bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] pend_x_q;
    logic [WIDTH-1:0] pend_y_q;
    logic             pend_full_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] gcd_q;
    logic [CW-1:0]    iter_q;
    logic             out_vld_q;
    logic             ovf_q;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic x_opnd_ld;   // x <= pending X
    logic y_opnd_ld;   // y <= pending Y
    logic x_step;      // x <= x - y
    logic y_step;      // y <= y - x
    logic consume;     // both operands loaded together: buffer is drained
    logic capture;     // new pair accepted into the pending buffer
    logic cnt_sat;

    assign x_opnd_ld = bus.x_load & ~bus.x_sel;
    assign y_opnd_ld = bus.y_load & ~bus.y_sel;
    assign x_step    = bus.x_load &  bus.x_sel;
    assign y_step    = bus.y_load &  bus.y_sel;
    assign consume   = x_opnd_ld & y_opnd_ld;
    assign capture   = bus.in_valid & ~pend_full_q;
    assign cnt_sat   = (cnt_q == {CW{1'b1}});

    // ------------------------------------------------------------------
    // Pending operand buffer
    // ------------------------------------------------------------------
    // Capture is only possible while the buffer is empty. A consume in the
    // same cycle drains the old (stale) contents, and the capture then
    // refills it, so capture takes priority for pend_full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            pend_full_q <= 1'b0;
        end else begin
            if (capture) begin
                pend_x_q    <= bus.x_in;
                pend_y_q    <= bus.y_in;
                pend_full_q <= 1'b1;
            end else if (consume) begin
                pend_full_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready = ~pend_full_q;

    // ------------------------------------------------------------------
    // Working registers
    // ------------------------------------------------------------------
    // Both subtract steps read the pre-edge x/y, so a simultaneous x-step
    // and y-step behave like a parallel swap-subtract. Wrap-around is
    // intentional modular arithmetic. Control selects the legal direction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            if (x_opnd_ld) begin
                x_q <= pend_x_q;
            end else if (x_step) begin
                x_q <= x_q - y_q;
            end

            if (y_opnd_ld) begin
                y_q <= pend_y_q;
            end else if (y_step) begin
                y_q <= y_q - x_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Iteration counter
    // ------------------------------------------------------------------
    // Any operand load restarts the count, even if the other register is
    // stepping in the same cycle. Otherwise each cycle with at least one
    // subtract step counts once, saturating at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            if (x_opnd_ld | y_opnd_ld) begin
                cnt_q <= '0;
            end else if ((x_step | y_step) && !cnt_sat) begin
                cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    // ------------------------------------------------------------------
    // Result register
    // ------------------------------------------------------------------
    // gcd_load samples the pre-edge x and counter. Overwriting a result the
    // consumer has not taken this cycle marks ovf_err, which stays set until
    // reset. A load that coincides with a handshake just replaces the value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gcd_q     <= '0;
            iter_q    <= '0;
            out_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (bus.gcd_load) begin
                gcd_q     <= x_q;
                iter_q    <= cnt_q;
                out_vld_q <= 1'b1;
                if (out_vld_q && !bus.out_ready) begin
                    ovf_q <= 1'b1;
                end
            end else if (out_vld_q && bus.out_ready) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign bus.gcd_out   = gcd_q;
    assign bus.iter_out  = iter_q;
    assign bus.out_valid = out_vld_q;
    assign bus.ovf_err   = ovf_q;

    // ------------------------------------------------------------------
    // Flags to control
    // ------------------------------------------------------------------
    // These are pure decodes of the working registers, so the FSM sees them
    // in the cycle after any load or step.
    assign bus.eq_flag  = (x_q == y_q);
    assign bus.if_flag  = (x_q <  y_q);
    assign bus.zero_err = (x_q == '0) || (y_q == '0);

endmodule
